fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
- Front end of the single-cycle R-type core. Holds the PC and a loadable instruction memory, fetches one word per cycle, and decodes RV32I R-type fields into register numbers and control.
- Drives read_reg_num1, read_reg_num2, write_reg, alu_control and regwrite of the downstream datapath.
- The datapath registers alu_control, regwrite and write_reg internally. This block therefore presents all decoded outputs as registered values, valid one cycle after fetch.

Parameters:
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words (power of two, 2..1024).
- AW, 6, word-address width; must equal log2(IMEM_DEPTH).

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  in IDLE or HALT: clear PC, enter RUN.
- stall  in  1  in RUN: hold PC and state, suppress issue.
- imem_we  in  1  instruction memory write enable (honoured only outside RUN).
- imem_addr  in  AW  word address for load.
- imem_wdata  in  32  instruction word for load.
- pc  out  32  byte address of the next fetch.
- read_reg_num1  out  5  rs1 = instr[19:15].
- read_reg_num2  out  5  rs2 = instr[24:20].
- write_reg  out  5  rd = instr[11:7].
- alu_control  out  4  decoded ALU operation.
- regwrite  out  1  write-back enable for this instruction.
- illegal  out  1  one-cycle pulse: fetched word was not a supported R-type.
- halted  out  1  high while in HALT.

Behaviour:
- Reset:
  - State IDLE, pc=0.
  - All decoded outputs, regwrite, illegal and halted are 0.
  - Memory contents are not cleared.
  - Reset mid-RUN aborts immediately; the next cycle issues nothing.
- States: IDLE, RUN, HALT.
  - IDLE: start -> RUN.
  - RUN: halt condition -> HALT.
  - HALT: start -> RUN.
- Entering RUN: pc <= 0.
- RUN issue cycle (stall=0):
  - Read imem[pc[AW+1:2]] combinationally and decode.
  - Register the fields and control into the outputs.
  - pc <= pc + 4.
- Stall in RUN: pc holds; regwrite <= 0; illegal <= 0; field outputs hold their previous values.
- Outside RUN, and in the cycle after leaving RUN, regwrite=0 and illegal=0. Field outputs hold.
- Decode applies only when opcode instr[6:0] = 7'b0110011:
  - funct7=0000000, funct3=000 -> ADD 0010
  - funct7=0100000, funct3=000 -> SUB 0100
  - funct7=0000000, funct3=111 -> AND 0000
  - funct7=0000000, funct3=110 -> OR 0001
  - funct7=0000000, funct3=100 -> XOR 0110
  - funct7=0000000, funct3=001 -> SLL 0011
  - funct7=0000000, funct3=101 -> SRL 0101
  - funct7=0000000, funct3=010 -> SLT 1000
  - Any other combination is illegal.
- Supported instruction: regwrite <= (rd != 0); illegal <= 0.
- Illegal non-zero word: alu_control <= 0000, regwrite <= 0, illegal <= 1 for one cycle. Fields still update. PC advances.
- Halt word 32'h00000000: no issue, regwrite <= 0, illegal <= 0, state -> HALT, pc holds at the halt word address.
- End of memory: after issuing the word at index IMEM_DEPTH-1, state -> HALT and pc holds at IMEM_DEPTH*4. No wrap-around.
- halted is registered: high the cycle after entering HALT, low the cycle after start.
- Simultaneous events:
  - start and stall together in IDLE/HALT: start wins. stall is ignored outside RUN.
  - reset overrides start, stall and imem_we.
- imem_we during RUN is ignored and leaves memory unchanged. Outside RUN the write takes effect at the clock edge.
- Latency:
  - Fetch of word k occurs in issue cycle k.
  - Its decoded outputs are visible from the following edge for exactly one cycle unless the next cycle stalls.

Test Plan:
- Reset then load imem[0]=32'h002081B3 (add x3,x1,x2), imem[1]=0, start -> cycle after first issue: rs1=1, rs2=2, rd=3, alu_control=0010, regwrite=1; then halted=1, pc=4.
- Load sub x5,x6,x7 (32'h407302B3) then halt word -> alu_control=0100, write_reg=5, regwrite=1; an instruction with rd=0 gives regwrite=0.
- Load word 32'h00000013 (addi) -> illegal=1 for one cycle, regwrite=0, alu_control=0000, pc advances by 4.
- Stall held 3 cycles mid-program -> pc constant, regwrite=0 during the stall; the next instruction issues normally after release.
- Fill all IMEM_DEPTH words with add -> exactly 64 regwrite pulses, then halted=1, pc=256, no wrap.
- Assert reset in RUN while asserting imem_we -> the write is ignored, pc=0, state IDLE, outputs 0, and memory contents persist on the next start.

Source files
------------

// File: rtl/fetch_decode_unit_if.sv
// Bus between the fetch/decode front end and its environment: start/stall
// control, instruction-memory load port, and the registered decode outputs.
interface fetch_decode_unit_if #(
  parameter int AW = 6
);
  logic          start;
  logic          stall;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [31:0]   pc;
  logic [4:0]    read_reg_num1;
  logic [4:0]    read_reg_num2;
  logic [4:0]    write_reg;
  logic [3:0]    alu_control;
  logic          regwrite;
  logic          illegal;
  logic          halted;

  modport master (
    output start, stall, imem_we, imem_addr, imem_wdata,
    input  pc, read_reg_num1, read_reg_num2, write_reg, alu_control,
           regwrite, illegal, halted
  );

  modport slave (
    input  start, stall, imem_we, imem_addr, imem_wdata,
    output pc, read_reg_num1, read_reg_num2, write_reg, alu_control,
           regwrite, illegal, halted
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: PC, loadable instruction memory and RV32I R-type
// decode; every decoded output is registered one cycle after its fetch.
module fetch_decode_unit #(
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  fetch_decode_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [6:0]  OP_RTYPE = 7'b0110011;
  localparam logic [31:0] LAST_PC  = 32'((IMEM_DEPTH - 1) * 4);

  logic [31:0] mem [IMEM_DEPTH];

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic [31:0] instr_p0;
  logic        fetch_p0;
  logic        issue_p0;
  logic        halt_word_p0;
  logic        last_word_p0;
  logic        legal_p0;
  logic [3:0]  alu_p0;

  logic [4:0]  rs1_p1, rs1_d;
  logic [4:0]  rs2_p1, rs2_d;
  logic [4:0]  rd_p1,  rd_d;
  logic [3:0]  alu_p1, alu_d;
  logic        regwrite_p1, regwrite_d;
  logic        illegal_p1,  illegal_d;
  logic        halted_p1,   halted_d;

  // Returns {legal, alu_control}; anything outside the supported R-type set is illegal.
  function automatic logic [4:0] decode_alu(input logic [31:0] w);
    logic [4:0] r;
    r = 5'b0_0000;
    if (w[6:0] == OP_RTYPE) begin
      case ({w[31:25], w[14:12]})
        {7'b0000000, 3'b000}: r = {1'b1, 4'b0010};
        {7'b0100000, 3'b000}: r = {1'b1, 4'b0100};
        {7'b0000000, 3'b111}: r = {1'b1, 4'b0000};
        {7'b0000000, 3'b110}: r = {1'b1, 4'b0001};
        {7'b0000000, 3'b100}: r = {1'b1, 4'b0110};
        {7'b0000000, 3'b001}: r = {1'b1, 4'b0011};
        {7'b0000000, 3'b101}: r = {1'b1, 4'b0101};
        {7'b0000000, 3'b010}: r = {1'b1, 4'b1000};
        default:              r = 5'b0_0000;
      endcase
    end
    return r;
  endfunction

  // Stage p0: combinational fetch and decode of the word at pc
  assign instr_p0     = mem[pc_q[AW+1:2]];
  assign fetch_p0     = (state_q == RUN) && !bus.stall;
  assign halt_word_p0 = (instr_p0 == 32'h0000_0000);
  assign issue_p0     = fetch_p0 && !halt_word_p0;
  assign last_word_p0 = (pc_q == LAST_PC);
  assign {legal_p0, alu_p0} = decode_alu(instr_p0);

  // Memory loads only outside RUN; contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && bus.imem_we && (state_q != RUN)) begin
      mem[bus.imem_addr] <= bus.imem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      HALT:    if (bus.start) state_d = RUN;
      RUN:     if (fetch_p0 && (halt_word_p0 || last_word_p0)) state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    rs1_d      = rs1_p1;
    rs2_d      = rs2_p1;
    rd_d       = rd_p1;
    alu_d      = alu_p1;
    regwrite_d = 1'b0;
    illegal_d  = 1'b0;
    halted_d   = (state_d == HALT);
    if ((state_q != RUN) && bus.start) begin
      pc_d = 32'h0000_0000;
    end else if (issue_p0) begin
      // After the last word pc parks at IMEM_DEPTH*4; no wrap-around.
      pc_d  = pc_q + 32'd4;
      rs1_d = instr_p0[19:15];
      rs2_d = instr_p0[24:20];
      rd_d  = instr_p0[11:7];
      if (legal_p0) begin
        alu_d      = alu_p0;
        regwrite_d = |instr_p0[11:7];
      end else begin
        alu_d     = 4'b0000;
        illegal_d = 1'b1;
      end
    end
  end

  // Stage p1: registered decode outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= 32'h0000_0000;
      rs1_p1      <= 5'd0;
      rs2_p1      <= 5'd0;
      rd_p1       <= 5'd0;
      alu_p1      <= 4'd0;
      regwrite_p1 <= 1'b0;
      illegal_p1  <= 1'b0;
      halted_p1   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rs1_p1      <= rs1_d;
      rs2_p1      <= rs2_d;
      rd_p1       <= rd_d;
      alu_p1      <= alu_d;
      regwrite_p1 <= regwrite_d;
      illegal_p1  <= illegal_d;
      halted_p1   <= halted_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.read_reg_num1 = rs1_p1;
  assign bus.read_reg_num2 = rs2_p1;
  assign bus.write_reg     = rd_p1;
  assign bus.alu_control   = alu_p1;
  assign bus.regwrite      = regwrite_p1;
  assign bus.illegal       = illegal_p1;
  assign bus.halted        = halted_p1;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: a program-level reference model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_fetch_decode_unit;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clock = 1'b0;
  logic reset;

  fetch_decode_unit_if #(.AW(AW)) bus ();

  fetch_decode_unit #(.IMEM_DEPTH(DEPTH), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        rw;
    logic        ill;
    logic        hlt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   rw_pulses = 0;

  // Supported R-type operations: funct7, funct3 and ALU code
  logic [6:0] t7[8] = '{7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000,
                        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
  logic [2:0] t3[8] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [3:0] ta[8] = '{4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b0110, 4'b0011, 4'b0101, 4'b1000};

  // Reference model state: program memory, running/halted flags, pc, held outputs
  logic [31:0] mmem[DEPTH];
  bit          m_run = 0;
  bit          m_hlt = 0;
  logic [31:0] m_pc  = '0;
  exp_t        m_out = '0;

  task automatic model_step(input logic st, input logic sl, input logic we,
                            input logic [AW-1:0] a, input logic [31:0] d, input logic rs);
    exp_t        e;
    logic [31:0] w;
    bit          found;
    e = m_out;
    if (rs) begin
      m_run = 0; m_hlt = 0; m_pc = '0; e = '0;
    end else begin
      e.rw = 0; e.ill = 0;
      if (!m_run) begin
        if (we) mmem[a] = d;
        if (st) begin m_run = 1; m_hlt = 0; m_pc = '0; end
      end else if (!sl) begin
        w = mmem[m_pc / 4];
        if (w == 32'h0) begin
          m_run = 0; m_hlt = 1;
        end else begin
          e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
          found = 0;
          for (int i = 0; i < 8; i++)
            if (w[6:0] == 7'h33 && w[31:25] == t7[i] && w[14:12] == t3[i]) begin
              found = 1; e.alu = ta[i];
            end
          if (found) e.rw = (w[11:7] != 5'd0);
          else begin e.alu = 4'b0000; e.ill = 1; end
          m_pc = m_pc + 4;
          if (m_pc == DEPTH * 4) begin m_run = 0; m_hlt = 1; end
        end
      end
    end
    e.pc  = m_pc;
    e.hlt = m_hlt;
    m_out = e;
    q.push_back(e);
  endtask

  task automatic drive(input logic st, input logic sl, input logic we,
                       input logic [AW-1:0] a, input logic [31:0] d, input logic rs);
    reset          = rs;
    bus.start      = st;
    bus.stall      = sl;
    bus.imem_we    = we;
    bus.imem_addr  = a;
    bus.imem_wdata = d;
    model_step(st, sl, we, a, d, rs);
    @(negedge clock);
  endtask

  task automatic load(input int a, input logic [31:0] w);
    drive(0, 0, 1, AW'(a), w, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, 0);
  endtask

  // Start the program and run it to completion with random stalls and ignored loads/starts
  task automatic run_prog(input int stall_pct, input bit noise);
    drive(1, 0, 0, '0, '0, 0);
    for (int i = 0; i < 400 && m_run; i++) begin
      drive(noise ? 1'($urandom) : 1'b0,
            ($urandom_range(0, 99) < stall_pct),
            noise ? ($urandom_range(0, 4) == 0) : 1'b0,
            AW'($urandom), $urandom, 0);
    end
    idle(2);
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    int          i;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    i = $urandom_range(0, 7);
    if (k < 6)      w = {t7[i], 5'($urandom), 5'($urandom), t3[i], 5'($urandom), 7'h33};
    else if (k < 8) w = {7'($urandom), 10'($urandom), 3'($urandom), 5'($urandom), 7'h33};
    else            w = $urandom | 32'h0000_0100;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (bus.regwrite === 1'b1) rw_pulses++;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty actual=none required=entry at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("pc",          bus.pc,            e.pc);
        chk("rs1",         32'(bus.read_reg_num1), 32'(e.rs1));
        chk("rs2",         32'(bus.read_reg_num2), 32'(e.rs2));
        chk("write_reg",   32'(bus.write_reg),     32'(e.rd));
        chk("alu_control", 32'(bus.alu_control),   32'(e.alu));
        chk("regwrite",    32'(bus.regwrite),      32'(e.rw));
        chk("illegal",     32'(bus.illegal),       32'(e.ill));
        chk("halted",      32'(bus.halted),        32'(e.hlt));
      end
    end
  end

  initial begin
    drive(0, 0, 0, '0, '0, 1);
    drive(1, 1, 1, '0, 32'h1234_5678, 1);
    for (int a = 0; a < DEPTH; a++) load(a, 32'h0);

    // add x3,x1,x2 then halt
    load(0, 32'h0020_81B3); load(1, 32'h0);
    run_prog(0, 0);

    // sub x5,x6,x7; add x0,x1,x2 (no write-back); halt
    load(0, 32'h4073_02B3); load(1, 32'h0020_8033); load(2, 32'h0);
    run_prog(0, 0);

    // addi is not a supported R-type
    load(0, 32'h0000_0013); load(1, 32'h4073_02B3); load(2, 32'h0);
    run_prog(0, 0);

    // Three-cycle stall mid-program
    for (int a = 0; a < 5; a++) load(a, {7'b0, 5'd2, 5'd1, 3'b000, 5'(a + 1), 7'h33});
    load(5, 32'h0);
    drive(1, 0, 0, '0, '0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, '0, '0, 0);
    idle(6);

    // Randomized programs with random stalls and ignored writes/starts in RUN
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(3, 20);
      for (int a = 0; a < n; a++) load(a, rand_instr());
      load(n, ($urandom_range(0, 2) == 0) ? rand_instr() : 32'h0);
      run_prog(25, 1);
    end

    // Whole memory of adds: run off the end and stop at DEPTH*4
    for (int a = 0; a < DEPTH; a++) load(a, 32'h0020_81B3);
    rw_pulses = 0;
    run_prog(0, 0);
    chk("regwrite_pulses", rw_pulses, DEPTH);

    // Reset mid-RUN with a simultaneous load; memory must be untouched
    load(0, 32'h0073_7233); load(1, 32'h4073_02B3); load(2, 32'h0);
    drive(1, 0, 0, '0, '0, 0);
    idle(1);
    drive(1, 1, 1, '0, 32'hDEAD_BEEF, 1);
    idle(2);
    run_prog(0, 0);

    idle(2);
    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
